// File: rtl/if_stage_pkg.sv
// Shared CPU constants for the fetch stage: jump-select codes, the NOP word,
// default reset/interrupt vectors and the IF/ID payload type.
package if_stage_pkg;

    localparam logic [1:0]  JUMP_NONE = 2'b00;
    localparam logic [1:0]  JUMP_IMM  = 2'b01;
    localparam logic [1:0]  JUMP_REG  = 2'b10;
    localparam logic [1:0]  JUMP_RSVD = 2'b11;

    localparam logic [31:0] NOP_WORD           = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [31:0] INT_VECTOR_DEFAULT = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // Sequential fetch address; wraps naturally modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load, flush and hold; flush wins over load.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc4_in,
    input  logic [31:0] instr_in,
    output logic [31:0] pc4_out,
    output logic [31:0] instr_out,
    output logic        valid_out
);

    if_id_t entry_q;
    if_id_t entry_d;

    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            entry_d.pc4   = 32'h0;
            entry_d.instr = NOP_WORD;
            entry_d.valid = 1'b0;
        end else if (load) begin
            entry_d.pc4   = pc4_in;
            entry_d.instr = instr_in;
            entry_d.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q.pc4   <= 32'h0;
            entry_q.instr <= NOP_WORD;
            entry_q.valid <= 1'b0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign pc4_out   = entry_q.pc4;
    assign instr_out = entry_q.instr;
    assign valid_out = entry_q.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC selection with redirect/interrupt priority,
// sticky interrupt pending flag, EPC capture and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        IF_IDWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [1:0]  jump_sel,
    input  logic [31:0] jump_target,
    input  logic [31:0] jr_target,
    input  logic        eret,
    input  logic [31:0] epc_in,
    input  logic        int_req,
    input  logic        int_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic        int_ack,
    output logic [31:0] epc_out
);

    logic [31:0] pc_q, pc_d;
    logic        int_pend_q, int_pend_d;
    logic        int_ack_q, int_ack_d;
    logic [31:0] epc_q, epc_d;

    logic        jump_active;
    logic        redirect;
    logic        accept;
    logic        flush;
    logic [31:0] pc4;

    always_comb begin
        pc4         = pc_plus4(pc_q);
        jump_active = !(jump_sel inside {JUMP_NONE, JUMP_RSVD});
        redirect    = eret | jump_active | branch_taken;
        // A redirect in ID or a stalled PC defers the interrupt; int_pend stays set.
        accept      = int_pend_q & int_en & PCWrite & ~redirect;
        flush       = PCWrite & (redirect | accept);

        pc_d = pc_q;
        if (PCWrite) begin
            if (accept) begin
                pc_d = INT_VECTOR;
            end else if (eret) begin
                pc_d = epc_in;
            end else if (jump_sel == JUMP_IMM) begin
                pc_d = jump_target;
            end else if (jump_sel == JUMP_REG) begin
                pc_d = jr_target;
            end else if (branch_taken) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc4;
            end
        end

        int_pend_d = accept ? 1'b0 : (int_pend_q | int_req);
        int_ack_d  = accept;
        epc_d      = accept ? pc_q : epc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            int_pend_q <= 1'b0;
            int_ack_q  <= 1'b0;
            epc_q      <= 32'h0;
        end else begin
            pc_q       <= pc_d;
            int_pend_q <= int_pend_d;
            int_ack_q  <= int_ack_d;
            epc_q      <= epc_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (IF_IDWrite),
        .flush     (flush),
        .pc4_in    (pc4),
        .instr_in  (imem_data),
        .pc4_out   (IF_ID_PC4),
        .instr_out (IF_ID_Instr),
        .valid_out (IF_ID_Valid)
    );

    assign imem_addr = pc_q;
    assign int_ack   = int_ack_q;
    assign epc_out   = epc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns addr ^ 32'hDEAD_0000.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic        IF_IDWrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [1:0]  jump_sel;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        eret;
    logic [31:0] epc_in;
    logic        int_req;
    logic        int_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        int_ack;
    logic [31:0] epc_out;

    int n_cmp = 0;
    int n_mis = 0;

    if_stage #(
        .RESET_PC   (32'h0000_0000),
        .INT_VECTOR (32'h0000_0004)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .IF_IDWrite    (IF_IDWrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_sel      (jump_sel),
        .jump_target   (jump_target),
        .jr_target     (jr_target),
        .eret          (eret),
        .epc_in        (epc_in),
        .int_req       (int_req),
        .int_en        (int_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .IF_ID_PC4     (IF_ID_PC4),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .int_ack       (int_ack),
        .epc_out       (epc_out)
    );

    assign imem_data = imem_addr ^ 32'hDEAD_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        PCWrite       = 1'b1;
        IF_IDWrite    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump_sel      = 2'b00;
        jump_target   = 32'h0;
        jr_target     = 32'h0;
        eret          = 1'b0;
        epc_in        = 32'h0;
        int_req       = 1'b0;
        int_en        = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        #2;
        if (imem_addr !== 32'h0) begin $display("FAIL rst_pc: got %h want %h", imem_addr, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h0) begin $display("FAIL rst_pc4: got %h want %h", IF_ID_PC4, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'h0) begin $display("FAIL rst_instr: got %h want %h", IF_ID_Instr, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL rst_valid: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        if (int_ack !== 1'b0) begin $display("FAIL rst_ack: got %b want 0", int_ack); n_mis++; end n_cmp++;
        if (epc_out !== 32'h0) begin $display("FAIL rst_epc: got %h want %h", epc_out, 32'h0); n_mis++; end n_cmp++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        if (imem_addr !== 32'h0) begin $display("FAIL seq_pc0: got %h want %h", imem_addr, 32'h0); n_mis++; end n_cmp++;
        tick();
        if (imem_addr !== 32'h4) begin $display("FAIL seq_pc1: got %h want %h", imem_addr, 32'h4); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h4) begin $display("FAIL seq_pc4_1: got %h want %h", IF_ID_PC4, 32'h4); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'hDEAD_0000) begin $display("FAIL seq_instr1: got %h want %h", IF_ID_Instr, 32'hDEAD_0000); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b1) begin $display("FAIL seq_valid1: got %b want 1", IF_ID_Valid); n_mis++; end n_cmp++;
        tick();
        if (imem_addr !== 32'h8) begin $display("FAIL seq_pc2: got %h want %h", imem_addr, 32'h8); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'hDEAD_0004) begin $display("FAIL seq_instr2: got %h want %h", IF_ID_Instr, 32'hDEAD_0004); n_mis++; end n_cmp++;
        tick();
        tick();
        if (imem_addr !== 32'h10) begin $display("FAIL seq_pc4th: got %h want %h", imem_addr, 32'h10); n_mis++; end n_cmp++;
        $display("test_sequential done");
    endtask

    task automatic test_stall_then_branch();
        PCWrite       = 1'b0;
        IF_IDWrite    = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        tick();
        tick();
        if (imem_addr !== 32'h10) begin $display("FAIL stall_pc: got %h want %h", imem_addr, 32'h10); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h10) begin $display("FAIL stall_pc4: got %h want %h", IF_ID_PC4, 32'h10); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'hDEAD_000C) begin $display("FAIL stall_instr: got %h want %h", IF_ID_Instr, 32'hDEAD_000C); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b1) begin $display("FAIL stall_valid: got %b want 1", IF_ID_Valid); n_mis++; end n_cmp++;
        PCWrite = 1'b1;
        tick();
        if (imem_addr !== 32'h40) begin $display("FAIL br_pc: got %h want %h", imem_addr, 32'h40); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL br_flush_valid: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'h0) begin $display("FAIL br_flush_instr: got %h want %h", IF_ID_Instr, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h0) begin $display("FAIL br_flush_pc4: got %h want %h", IF_ID_PC4, 32'h0); n_mis++; end n_cmp++;
        $display("test_stall_then_branch done");
    endtask

    task automatic test_priority();
        set_idle();
        jump_sel = 2'b10; jr_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        if (imem_addr !== 32'h100) begin $display("FAIL jr_over_br: got %h want %h", imem_addr, 32'h100); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL jr_flush: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        jump_sel = 2'b01; jump_target = 32'h200;
        tick();
        if (imem_addr !== 32'h200) begin $display("FAIL j_over_br: got %h want %h", imem_addr, 32'h200); n_mis++; end n_cmp++;
        eret = 1'b1; epc_in = 32'h300;
        tick();
        if (imem_addr !== 32'h300) begin $display("FAIL eret_over_j: got %h want %h", imem_addr, 32'h300); n_mis++; end n_cmp++;
        set_idle();
        jump_sel = 2'b11; jump_target = 32'h500; jr_target = 32'h600;
        tick();
        if (imem_addr !== 32'h304) begin $display("FAIL jsel11_pc: got %h want %h", imem_addr, 32'h304); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b1) begin $display("FAIL jsel11_valid: got %b want 1", IF_ID_Valid); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'hDEAD_0300) begin $display("FAIL jsel11_instr: got %h want %h", IF_ID_Instr, 32'hDEAD_0300); n_mis++; end n_cmp++;
        jump_sel = 2'b01; jump_target = 32'hFFFF_FFFC;
        tick();
        if (imem_addr !== 32'hFFFF_FFFC) begin $display("FAIL wrap_pc_a: got %h want %h", imem_addr, 32'hFFFF_FFFC); n_mis++; end n_cmp++;
        set_idle();
        tick();
        if (imem_addr !== 32'h0) begin $display("FAIL wrap_pc_b: got %h want %h", imem_addr, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h0) begin $display("FAIL wrap_pc4: got %h want %h", IF_ID_PC4, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_Instr !== 32'h2152_FFFC) begin $display("FAIL wrap_instr: got %h want %h", IF_ID_Instr, 32'h2152_FFFC); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b1) begin $display("FAIL wrap_valid: got %b want 1", IF_ID_Valid); n_mis++; end n_cmp++;
        $display("test_priority done");
    endtask

    task automatic test_interrupt();
        set_idle();
        for (int i = 0; i < 7; i++) tick();
        if (imem_addr !== 32'h1C) begin $display("FAIL int_pre_pc: got %h want %h", imem_addr, 32'h1C); n_mis++; end n_cmp++;
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        if (imem_addr !== 32'h20) begin $display("FAIL int_pend_pc: got %h want %h", imem_addr, 32'h20); n_mis++; end n_cmp++;
        if (int_ack !== 1'b0) begin $display("FAIL int_early_ack: got %b want 0", int_ack); n_mis++; end n_cmp++;
        tick();
        if (imem_addr !== 32'h4) begin $display("FAIL int_vec: got %h want %h", imem_addr, 32'h4); n_mis++; end n_cmp++;
        if (epc_out !== 32'h20) begin $display("FAIL int_epc: got %h want %h", epc_out, 32'h20); n_mis++; end n_cmp++;
        if (int_ack !== 1'b1) begin $display("FAIL int_ack_hi: got %b want 1", int_ack); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL int_flush: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        tick();
        if (int_ack !== 1'b0) begin $display("FAIL int_ack_lo: got %b want 0", int_ack); n_mis++; end n_cmp++;
        if (imem_addr !== 32'h8) begin $display("FAIL int_after_pc: got %h want %h", imem_addr, 32'h8); n_mis++; end n_cmp++;
        if (epc_out !== 32'h20) begin $display("FAIL int_epc_hold: got %h want %h", epc_out, 32'h20); n_mis++; end n_cmp++;
        $display("test_interrupt done");
    endtask

    task automatic test_deferred();
        set_idle();
        int_en = 1'b0; int_req = 1'b1;
        tick();
        int_req = 1'b0;
        tick();
        if (imem_addr !== 32'h10) begin $display("FAIL def_en_pc: got %h want %h", imem_addr, 32'h10); n_mis++; end n_cmp++;
        if (int_ack !== 1'b0) begin $display("FAIL def_en_ack: got %b want 0", int_ack); n_mis++; end n_cmp++;
        int_en = 1'b1; branch_taken = 1'b1; branch_target = 32'h60;
        tick();
        if (imem_addr !== 32'h60) begin $display("FAIL def_br_pc: got %h want %h", imem_addr, 32'h60); n_mis++; end n_cmp++;
        if (int_ack !== 1'b0) begin $display("FAIL def_br_ack: got %b want 0", int_ack); n_mis++; end n_cmp++;
        branch_taken = 1'b0;
        tick();
        if (imem_addr !== 32'h4) begin $display("FAIL def_acc_pc: got %h want %h", imem_addr, 32'h4); n_mis++; end n_cmp++;
        if (epc_out !== 32'h60) begin $display("FAIL def_acc_epc: got %h want %h", epc_out, 32'h60); n_mis++; end n_cmp++;
        if (int_ack !== 1'b1) begin $display("FAIL def_acc_ack: got %b want 1", int_ack); n_mis++; end n_cmp++;
        tick();
        eret = 1'b1; epc_in = 32'h60;
        tick();
        eret = 1'b0;
        if (imem_addr !== 32'h60) begin $display("FAIL eret_pc: got %h want %h", imem_addr, 32'h60); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL eret_flush: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        $display("test_deferred done");
    endtask

    task automatic test_async_reset();
        set_idle();
        tick();
        PCWrite = 1'b0; IF_IDWrite = 1'b0; int_req = 1'b1;
        tick();
        if (imem_addr !== 32'h64) begin $display("FAIL ar_stall_pc: got %h want %h", imem_addr, 32'h64); n_mis++; end n_cmp++;
        #2;
        rst_n = 1'b0;
        #1;
        if (imem_addr !== 32'h0) begin $display("FAIL ar_pc: got %h want %h", imem_addr, 32'h0); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b0) begin $display("FAIL ar_valid: got %b want 0", IF_ID_Valid); n_mis++; end n_cmp++;
        if (IF_ID_PC4 !== 32'h0) begin $display("FAIL ar_pc4: got %h want %h", IF_ID_PC4, 32'h0); n_mis++; end n_cmp++;
        if (epc_out !== 32'h0) begin $display("FAIL ar_epc: got %h want %h", epc_out, 32'h0); n_mis++; end n_cmp++;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        if (imem_addr !== 32'h4) begin $display("FAIL ar_rel_pc: got %h want %h", imem_addr, 32'h4); n_mis++; end n_cmp++;
        if (IF_ID_Valid !== 1'b1) begin $display("FAIL ar_rel_valid: got %b want 1", IF_ID_Valid); n_mis++; end n_cmp++;
        if (int_ack !== 1'b0) begin $display("FAIL ar_rel_ack: got %b want 0", int_ack); n_mis++; end n_cmp++;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_then_branch();
        test_priority();
        test_interrupt();
        test_deferred();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
